// File: rtl/prog_loader_arb_pkg.sv
// rtl/prog_loader_arb_pkg.sv - shared states and constants for the program loader
package prog_loader_arb_pkg;

  localparam int IMEM_ADDR_W = 17;

  localparam logic [7:0] ACK_BYTE_C = 8'hAA;
  localparam logic [7:0] ERR_BYTE_C = 8'hEE;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    WR   = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4,
    RUN  = 3'd5
  } state_e;

endpackage

// File: rtl/prog_loader_arb_byte_assembler.sv
// rtl/prog_loader_arb_byte_assembler.sv - packs four bytes little-endian into a 32-bit word
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
  assign word       = {byte_data, shift_q[31:8]};
  assign word_valid = byte_valid && !clr && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = 2'd0;
      shift_d = 32'd0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader_arb.sv
// rtl/prog_loader_arb.sv - loads a UART program image into instruction memory, then hands the port to fetch
module prog_loader_arb
  import prog_loader_arb_pkg::*;
#(
  parameter int         ADDR_W   = IMEM_ADDR_W,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_C,
  parameter logic [7:0] ERR_BYTE = ERR_BYTE_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              core_run
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [31:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                asm_valid;
  logic                asm_clr;
  logic                asm_word_valid;
  logic [31:0]         asm_word;

  // WR still feeds the assembler so a byte landing there becomes byte 0 of the next word.
  assign asm_valid = rx_valid && ((state_q == HDR) || (state_q == DATA) || (state_q == WR));
  assign asm_clr   = (state_q == ERR) && tx_ready;

  byte_assembler u_byte_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word_valid (asm_word_valid),
    .word       (asm_word)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      HDR: begin
        if (asm_word_valid) begin
          word_cnt_d = asm_word;
          if (asm_word == 32'd0) begin
            state_d = ACK;
          end else if ({1'b0, asm_word} > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            addr_d  = '0;
          end
        end
      end
      DATA: begin
        if (asm_word_valid) begin
          wdata_d = asm_word;
          state_d = WR;
        end
      end
      WR: begin
        addr_d     = addr_q + 1'b1;
        word_cnt_d = word_cnt_q - 32'd1;
        state_d    = (word_cnt_q == 32'd1) ? ACK : DATA;
      end
      ACK: begin
        if (tx_ready) state_d = RUN;
      end
      ERR: begin
        if (tx_ready) begin
          state_d    = HDR;
          word_cnt_d = 32'd0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR;
      word_cnt_q <= 32'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // All outputs decode straight from registered state, so none glitch on rx activity.
  assign core_run  = (state_q == RUN);
  assign mem_we    = (state_q == WR);
  assign mem_wdata = wdata_q;
  assign mem_addr  = core_run ? fetch_addr : addr_q;
  assign tx_valid  = (state_q == ACK) || (state_q == ERR);
  assign tx_data   = (state_q == ACK) ? ACK_BYTE :
                     (state_q == ERR) ? ERR_BYTE : 8'h00;

endmodule

// File: tb/tb_prog_loader_arb.sv
// tb/tb_prog_loader_arb.sv - directed self-checking bench for prog_loader_arb
module tb_prog_loader_arb;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_ready = 1'b0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              core_run;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int we0;

  prog_loader_arb u_dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .core_run   (core_run)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    idle(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  // Lands in the WR cycle after the 4th byte; gap=0 lets the next byte start there.
  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    check("wr_we", {31'd0, mem_we}, 32'd1);
    check("wr_addr", 32'(mem_addr), addr);
    check("wr_data", mem_wdata, w);
    if (gap) idle(1);
  endtask

  task automatic handshake(input logic [7:0] b, input int hold, input bit to_run);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      idle(1);
      n++;
    end
    check("tx_valid", {31'd0, tx_valid}, 32'd1);
    check("tx_data", {24'd0, tx_data}, {24'd0, b});
    for (int i = 0; i < hold; i++) begin
      idle(1);
      check("hold_valid", {31'd0, tx_valid}, 32'd1);
      check("hold_data", {24'd0, tx_data}, {24'd0, b});
      check("hold_run", {31'd0, core_run}, 32'd0);
    end
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    check("post_run", {31'd0, core_run}, {31'd0, to_run});
    check("post_valid", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_txv"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_txd"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_run"}, {31'd0, core_run}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outs("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    // Two-word load with idle gaps
    send_hdr(32'd2);
    send_word(32'h12345678, 32'd0, 1'b1);
    send_word(32'hDEADBEEF, 32'd1, 1'b1);
    handshake(8'hAA, 0, 1'b1);
    fetch_addr = 17'h00010;
    #1 check("fetch_pass", 32'(mem_addr), 32'h10);
    check("t1_we_cnt", 32'(we_cnt), 32'd2);

    // Zero-length image, transmitter stalled 10 cycles
    do_reset();
    we0 = we_cnt;
    send_hdr(32'd0);
    handshake(8'hAA, 10, 1'b1);
    check("t2_no_we", 32'(we_cnt), 32'(we0));

    // Oversized header, then a valid 1-word load
    do_reset();
    we0 = we_cnt;
    send_hdr(32'h00020001);
    check("err_addr", 32'(mem_addr), 32'd0);
    handshake(8'hEE, 0, 1'b0);
    check("t3_no_we", 32'(we_cnt), 32'(we0));
    send_hdr(32'd1);
    send_word(32'h44332211, 32'd0, 1'b1);
    handshake(8'hAA, 0, 1'b1);

    // Exactly 2^ADDR_W words is accepted
    do_reset();
    send_hdr(32'h00020000);
    idle(2);
    check("max_no_tx", {31'd0, tx_valid}, 32'd0);
    send_word(32'hCAFEF00D, 32'd0, 1'b1);

    // Back-to-back bytes, including during WR, then ignored bytes in RUN
    do_reset();
    send_hdr(32'd3);
    send_word(32'hA1B2C3D4, 32'd0, 1'b0);
    send_word(32'h0BADF00D, 32'd1, 1'b0);
    send_word(32'h55AA33CC, 32'd2, 1'b0);
    handshake(8'hAA, 0, 1'b1);
    we0 = we_cnt;
    for (int i = 0; i < 6; i++) send_byte(8'h5A + 8'(i));
    idle(1);
    check("run_no_we", 32'(we_cnt), 32'(we0));
    check("run_hold", {31'd0, core_run}, 32'd1);
    check("run_txv", {31'd0, tx_valid}, 32'd0);

    // Async reset mid-load, then a fresh load from address 0
    do_reset();
    send_hdr(32'd2);
    send_word(32'h01020304, 32'd0, 1'b1);
    send_byte(8'h77);
    send_byte(8'h88);
    rst = 1'b1;
    #2 check_reset_outs("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    send_hdr(32'd2);
    send_word(32'h90ABCDEF, 32'd0, 1'b1);
    send_word(32'h13572468, 32'd1, 1'b1);
    handshake(8'hAA, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
